// File: rtl/key_extract_arb_if.sv
// key_extract_arb_if
//   Bundle of the two parser-lane PHV handshakes, the engine issue/return
//   signals and the status outputs of key_extract_arb.
//   slave  : arbiter view (takes PHVs, drives engine and status)
//   master : driver view (presents PHVs, returns keys, observes status)
// Parameters must match the arbiter instance: PHV_LEN, TAG_DEPTH.
interface key_extract_arb_if #(
   parameter int PHV_LEN   = 1579,
   parameter int TAG_DEPTH = 4
);
   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

   logic               s0_phv_valid;
   logic [PHV_LEN-1:0] s0_phv_data;
   logic               s0_phv_ready;
   logic               s1_phv_valid;
   logic [PHV_LEN-1:0] s1_phv_data;
   logic               s1_phv_ready;
   logic               ke_parser_valid;
   logic [PHV_LEN-1:0] ke_pkt_hdr_vec;
   logic               ke_key_valid;
   logic               done_valid;
   logic               done_src;
   logic [CNT_W-1:0]   inflight;
   logic               err_orphan;

   modport slave (
      input  s0_phv_valid, s0_phv_data,
      input  s1_phv_valid, s1_phv_data,
      input  ke_key_valid,
      output s0_phv_ready, s1_phv_ready,
      output ke_parser_valid, ke_pkt_hdr_vec,
      output done_valid, done_src, inflight, err_orphan
   );

   modport master (
      output s0_phv_valid, s0_phv_data,
      output s1_phv_valid, s1_phv_data,
      output ke_key_valid,
      input  s0_phv_ready, s1_phv_ready,
      input  ke_parser_valid, ke_pkt_hdr_vec,
      input  done_valid, done_src, inflight, err_orphan
   );
endinterface

// File: rtl/key_extract_arb.sv
// key_extract_arb
//   Two-lane PHV arbiter and issue sequencer in front of one shared
//   key_extract engine. Accepted PHVs are issued as one-cycle
//   ke_parser_valid pulses spaced at least ISSUE_GAP cycles apart; an
//   in-order tag FIFO attributes every returned key to its source lane.
//
// Ports
//   axis_clk : clock
//   areset   : synchronous active-high reset
//   bus      : key_extract_arb_if.slave
//              s0/s1_phv_valid/data/ready - lane handshakes (ready is comb)
//              ke_parser_valid/ke_pkt_hdr_vec - registered engine issue
//              ke_key_valid - key-done pulse from the engine
//              done_valid/done_src - registered key attribution
//              inflight - tag FIFO occupancy
//              err_orphan - key returned with no tag outstanding
//
// Build option
//   KEY_ARB_STRICT_PRIO_EN : lane 0 always wins a tie (no round-robin).
//
// state | meaning
// IDLE  | may accept a PHV if a lane is valid and the tag FIFO has room
// GAP   | issue spacing; both readies low while gap_cnt counts down
module key_extract_arb #(
   parameter int PHV_LEN   = 1579,
   parameter int ISSUE_GAP = 2,
   parameter int TAG_DEPTH = 4
) (
   input logic              axis_clk,
   input logic              areset,
   key_extract_arb_if.slave bus
);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         gap_cnt_q, gap_cnt_d;
   logic               last_grant_q, last_grant_d;
   logic               pv_q, pv_d;
   logic [PHV_LEN-1:0] hdr_q, hdr_d;
   logic               done_valid_q, done_valid_d;
   logic               done_src_q, done_src_d;
   logic               orphan_q, orphan_d;
   logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   inflight_q, inflight_d;

   logic grant;
   logic can_accept;
   logic ready0, ready1;
   logic accept;
   logic pop;
   logic orphan;

   // Grant selection; only meaningful when at least one lane is valid.
   always_comb begin
      grant = 1'b0;
      if (bus.s0_phv_valid && bus.s1_phv_valid) begin
`ifdef KEY_ARB_STRICT_PRIO_EN
         grant = 1'b0;
`else
         grant = ~last_grant_q;
`endif
      end else if (bus.s1_phv_valid) begin
         grant = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge axis_clk) begin
      if (areset) begin
         state_q   <= IDLE;
         gap_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gap_cnt_q <= gap_cnt_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               gap_cnt_d = 4'(ISSUE_GAP - 1);
               state_d   = GAP;
            end
         end
         GAP: begin
            // <= 1 rather than == 1 so a corrupted zero cannot wrap to 15.
            if (gap_cnt_q <= 4'd1) begin
               gap_cnt_d = '0;
               state_d   = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 4'd1;
            end
         end
         default: begin
            gap_cnt_d = '0;
            state_d   = IDLE;
         end
      endcase
   end

   // FSM outputs. Room check uses the pre-pop count, so a pop in the same
   // cycle never frees a slot for a simultaneous push.
   always_comb begin
      can_accept = (state_q == IDLE) && !areset &&
                   (inflight_q < CNT_W'(TAG_DEPTH));
      ready0     = can_accept && bus.s0_phv_valid && !grant;
      ready1     = can_accept && bus.s1_phv_valid &&  grant;
      accept     = ready0 || ready1;
   end

   assign bus.s0_phv_ready = ready0;
   assign bus.s1_phv_ready = ready1;

   // Issue path, tag FIFO and key attribution
   always_comb begin
      pop          = bus.ke_key_valid && (inflight_q != '0);
      orphan       = bus.ke_key_valid && (inflight_q == '0);

      last_grant_d = last_grant_q;
      pv_d         = accept;
      hdr_d        = hdr_q;
      tag_mem_d    = tag_mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      inflight_d   = inflight_q;
      done_valid_d = pop;
      done_src_d   = done_src_q;
      orphan_d     = orphan;

      if (accept) begin
         last_grant_d         = grant;
         hdr_d                = grant ? bus.s1_phv_data : bus.s0_phv_data;
         tag_mem_d[wr_ptr_q]  = grant;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
         done_src_d = tag_mem_q[rd_ptr_q];
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end

      case ({accept, pop})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge axis_clk) begin
      if (areset) begin
         last_grant_q <= 1'b1;
         pv_q         <= 1'b0;
         hdr_q        <= '0;
         tag_mem_q    <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         inflight_q   <= '0;
         done_valid_q <= 1'b0;
         done_src_q   <= 1'b0;
         orphan_q     <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         pv_q         <= pv_d;
         hdr_q        <= hdr_d;
         tag_mem_q    <= tag_mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         inflight_q   <= inflight_d;
         done_valid_q <= done_valid_d;
         done_src_q   <= done_src_d;
         orphan_q     <= orphan_d;
      end
   end

   assign bus.ke_parser_valid = pv_q;
   assign bus.ke_pkt_hdr_vec  = hdr_q;
   assign bus.done_valid      = done_valid_q;
   assign bus.done_src        = done_src_q;
   assign bus.inflight        = inflight_q;
   assign bus.err_orphan      = orphan_q;

endmodule

// File: tb/tb_key_extract_arb.sv
// tb_key_extract_arb
//   Bench for key_extract_arb: a per-cycle reference model (issue times,
//   a lane queue, round-robin state) checks every output on every falling
//   edge; a per-cycle vector table, a few directed sequences and a random
//   phase provide stimulus. Honours KEY_ARB_STRICT_PRIO_EN.
module tb_key_extract_arb;
   localparam int PHV_LEN   = 1579;
   localparam int ISSUE_GAP = 2;
   localparam int TAG_DEPTH = 4;
`ifdef KEY_ARB_STRICT_PRIO_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   typedef logic [PHV_LEN-1:0] phv_t;

   logic axis_clk = 1'b0;
   logic areset;
   always #5 axis_clk = ~axis_clk;

   key_extract_arb_if #(.PHV_LEN(PHV_LEN), .TAG_DEPTH(TAG_DEPTH)) bus ();

   key_extract_arb #(
      .PHV_LEN  (PHV_LEN),
      .ISSUE_GAP(ISSUE_GAP),
      .TAG_DEPTH(TAG_DEPTH)
   ) dut (
      .axis_clk(axis_clk),
      .areset  (areset),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int   m_cyc     = 0;
   int   m_next_ok = 0;   // first cycle in which an accept is allowed
   bit   m_q[$];          // lanes of in-flight PHVs, oldest first
   bit   m_lg      = 1'b1;
   bit   m_pv, m_dv, m_src, m_orph;
   phv_t m_hdr;
   bit   m_started = 1'b0;

   function automatic void m_ready(output bit r0, output bit r1, output bit g);
      bit idle, room;
      g = 1'b0;
      if (bus.s0_phv_valid && bus.s1_phv_valid) g = STRICT ? 1'b0 : !m_lg;
      else if (bus.s1_phv_valid)                 g = 1'b1;
      idle = (m_cyc >= m_next_ok);
      room = (m_q.size() < TAG_DEPTH);
      r0 = !areset && idle && room && bus.s0_phv_valid && !g;
      r1 = !areset && idle && room && bus.s1_phv_valid &&  g;
   endfunction

   always @(posedge axis_clk) begin
      bit r0, r1, g;
      if (areset) begin
         m_q.delete();
         m_lg = 1'b1; m_pv = 1'b0; m_dv = 1'b0; m_src = 1'b0; m_orph = 1'b0;
         m_hdr = '0;
         m_next_ok = m_cyc + 1;
         m_started = 1'b1;
      end else if (m_started) begin
         m_ready(r0, r1, g);
         m_dv = 1'b0; m_orph = 1'b0;
         if (bus.ke_key_valid) begin
            if (m_q.size() > 0) begin
               m_src = m_q.pop_front();
               m_dv  = 1'b1;
            end else begin
               m_orph = 1'b1;
            end
         end
         m_pv = r0 || r1;
         if (r0 || r1) begin
            m_hdr = g ? bus.s1_phv_data : bus.s0_phv_data;
            m_q.push_back(g);
            m_lg = g;
            m_next_ok = m_cyc + ISSUE_GAP;
         end
      end
      m_cyc++;
   end

   always @(negedge axis_clk) begin
      bit r0, r1, g;
      if (m_started) begin
         m_ready(r0, r1, g);
         chk("mdl_s0_ready", bus.s0_phv_ready, r0);
         chk("mdl_s1_ready", bus.s1_phv_ready, r1);
         chk("mdl_parser_valid", bus.ke_parser_valid, m_pv);
         chk("mdl_inflight", bus.inflight, m_q.size());
         chk("mdl_done_valid", bus.done_valid, m_dv);
         chk("mdl_err_orphan", bus.err_orphan, m_orph);
         if (m_dv) chk("mdl_done_src", bus.done_src, m_src);
         n_tests++;
         if (bus.ke_pkt_hdr_vec !== m_hdr) begin
            n_fail++;
            $display("FAIL mdl_hdr: got[63:0] %h expected[63:0] %h at %0t",
                     bus.ke_pkt_hdr_vec[63:0], m_hdr[63:0], $time);
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic phv_t rnd_phv();
      phv_t v = '0;
      for (int i = 0; i < (PHV_LEN + 31) / 32; i++) v = {v[PHV_LEN-33:0], 32'($urandom)};
      return v;
   endfunction

   task automatic next_cyc();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic reset_dut();
      areset = 1'b1;
      bus.s0_phv_valid = 1'b0;
      bus.s1_phv_valid = 1'b0;
      bus.ke_key_valid = 1'b0;
      next_cyc();
      next_cyc();
      areset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit s0v, s1v, kv;
      bit r0, r1, pv;
      logic [7:0] hdr;
      int infl;
      bit dv, src, orph;
   } vec_t;

   vec_t tbl[16];

   task automatic run_table();
      tbl[0]  = '{1,0,0, 1,0,0, 8'h00, 0, 0,0,0};
      tbl[1]  = '{0,0,0, 0,0,1, 8'hA5, 1, 0,0,0};
      tbl[2]  = '{0,0,0, 0,0,0, 8'hA5, 1, 0,0,0};
      tbl[3]  = '{0,0,1, 0,0,0, 8'hA5, 1, 0,0,0};
      tbl[4]  = '{0,0,0, 0,0,0, 8'hA5, 0, 1,0,0};
      tbl[5]  = '{0,0,1, 0,0,0, 8'hA5, 0, 0,0,0};
      tbl[6]  = '{0,0,0, 0,0,0, 8'hA5, 0, 0,0,1};
      tbl[7]  = '{1,1,0, 0,1,0, 8'hA5, 0, 0,0,0};
      tbl[8]  = '{1,1,0, 0,0,1, 8'h5A, 1, 0,0,0};
      tbl[9]  = '{1,1,0, 1,0,0, 8'h5A, 1, 0,0,0};
      tbl[10] = '{0,1,0, 0,0,1, 8'hA5, 2, 0,0,0};
      tbl[11] = '{0,1,1, 0,1,0, 8'hA5, 2, 0,0,0};
      tbl[12] = '{0,0,0, 0,0,1, 8'h5A, 2, 1,1,0};
      tbl[13] = '{0,0,1, 0,0,0, 8'h5A, 2, 0,0,0};
      tbl[14] = '{0,0,1, 0,0,0, 8'h5A, 1, 1,0,0};
      tbl[15] = '{0,0,0, 0,0,0, 8'h5A, 0, 1,1,0};
      reset_dut();
      bus.s0_phv_data = phv_t'(8'hA5);
      bus.s1_phv_data = phv_t'(8'h5A);
      for (int i = 0; i < 16; i++) begin
         bus.s0_phv_valid = tbl[i].s0v;
         bus.s1_phv_valid = tbl[i].s1v;
         bus.ke_key_valid = tbl[i].kv;
         @(negedge axis_clk);
         chk("tbl_s0_ready", bus.s0_phv_ready, tbl[i].r0);
         chk("tbl_s1_ready", bus.s1_phv_ready, tbl[i].r1);
         chk("tbl_parser_valid", bus.ke_parser_valid, tbl[i].pv);
         chk("tbl_hdr", bus.ke_pkt_hdr_vec[63:0], 64'(tbl[i].hdr));
         chk("tbl_inflight", bus.inflight, tbl[i].infl);
         chk("tbl_done_valid", bus.done_valid, tbl[i].dv);
         chk("tbl_err_orphan", bus.err_orphan, tbl[i].orph);
         if (tbl[i].dv) chk("tbl_done_src", bus.done_src, tbl[i].src);
         next_cyc();
      end
      bus.s0_phv_valid = 1'b0; bus.s1_phv_valid = 1'b0; bus.ke_key_valid = 1'b0;
   endtask

   // Both lanes saturated, engine returns each key 2 cycles after issue.
   task automatic run_saturated();
      int grants[$];
      int dones[$];
      int issues[$];
      bit p1 = 1'b0, p2 = 1'b0;
      int orph = 0;
      reset_dut();
      for (int i = 0; i < 30; i++) begin
         bus.s0_phv_valid = (i < 20);
         bus.s1_phv_valid = (i < 20);
         bus.ke_key_valid = p2;
         @(negedge axis_clk);
         if (bus.s0_phv_valid && bus.s0_phv_ready) grants.push_back(0);
         if (bus.s1_phv_valid && bus.s1_phv_ready) grants.push_back(1);
         if (bus.done_valid) dones.push_back(int'(bus.done_src));
         if (bus.err_orphan) orph++;
         if (bus.ke_parser_valid) issues.push_back(i);
         p2 = p1;
         p1 = bus.ke_parser_valid;
         next_cyc();
      end
      bus.s0_phv_valid = 1'b0; bus.s1_phv_valid = 1'b0; bus.ke_key_valid = 1'b0;
      chk("sat_accepts", grants.size(), 10);
      chk("sat_dones", dones.size(), grants.size());
      chk("sat_orphans", orph, 0);
      for (int k = 0; k < grants.size(); k++) chk("sat_grant", grants[k], k % 2);
      for (int k = 0; k < dones.size() && k < grants.size(); k++)
         chk("sat_done_src", dones[k], grants[k]);
      for (int k = 1; k < issues.size(); k++)
         chk("sat_spacing", issues[k] - issues[k-1], ISSUE_GAP);
   endtask

   task automatic run_fifo_full();
      int acc = 0;
      reset_dut();
      bus.s0_phv_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge axis_clk);
         if (bus.s0_phv_ready) acc++;
         next_cyc();
      end
      chk("full_accepts", acc, TAG_DEPTH);
      bus.ke_key_valid = 1'b1;
      @(negedge axis_clk);
      chk("full_ready_blocked", bus.s0_phv_ready, 0);
      chk("full_inflight", bus.inflight, TAG_DEPTH);
      next_cyc();
      bus.ke_key_valid = 1'b0;
      @(negedge axis_clk);
      chk("full_inflight_after_pop", bus.inflight, TAG_DEPTH - 1);
      chk("full_ready_reopen", bus.s0_phv_ready, 1);
      next_cyc();
      bus.s0_phv_valid = 1'b0;
   endtask

   task automatic run_reset_tags();
      int acc = 0;
      reset_dut();
      bus.s0_phv_valid = 1'b1;
      for (int i = 0; i < 10 && acc < 3; i++) begin
         @(negedge axis_clk);
         if (bus.s0_phv_ready) acc++;
         next_cyc();
      end
      areset = 1'b1;
      @(negedge axis_clk);
      chk("rst_tags_before", bus.inflight, 3);
      chk("rst_ready_in_reset", bus.s0_phv_ready, 0);
      next_cyc();
      areset = 1'b0;
      bus.s0_phv_valid = 1'b0;
      bus.ke_key_valid = 1'b1;
      @(negedge axis_clk);
      chk("rst_inflight", bus.inflight, 0);
      next_cyc();
      bus.ke_key_valid = 1'b0;
      @(negedge axis_clk);
      chk("rst_orphan", bus.err_orphan, 1);
      chk("rst_no_done", bus.done_valid, 0);
      next_cyc();
   endtask

   task automatic run_strict();
      int g0 = 0, g1 = 0;
      bit p1 = 1'b0, p2 = 1'b0;
      bit seen1 = 1'b0;
      reset_dut();
      for (int i = 0; i < 12; i++) begin
         bus.s0_phv_valid = 1'b1;
         bus.s1_phv_valid = 1'b1;
         bus.ke_key_valid = p2;
         @(negedge axis_clk);
         if (bus.s0_phv_ready) g0++;
         if (bus.s1_phv_ready) g1++;
         p2 = p1;
         p1 = bus.ke_parser_valid;
         next_cyc();
      end
      chk("strict_lane0_grants", g0, 6);
      chk("strict_lane1_grants", g1, 0);
      bus.s0_phv_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.ke_key_valid = p2;
         @(negedge axis_clk);
         if (bus.s1_phv_ready) seen1 = 1'b1;
         p2 = p1;
         p1 = bus.ke_parser_valid;
         next_cyc();
      end
      chk("strict_lane1_after_drop", seen1, 1);
      bus.s1_phv_valid = 1'b0;
      bus.ke_key_valid = 1'b0;
   endtask

   task automatic run_random();
      reset_dut();
      for (int i = 0; i < 800; i++) begin
         areset           = ($urandom_range(0, 99) == 0);
         bus.s0_phv_valid = ($urandom_range(0, 3) != 0);
         bus.s1_phv_valid = ($urandom_range(0, 3) != 0);
         bus.ke_key_valid = ($urandom_range(0, 3) == 0);
         bus.s0_phv_data  = rnd_phv();
         bus.s1_phv_data  = rnd_phv();
         next_cyc();
      end
      areset = 1'b0;
      bus.s0_phv_valid = 1'b0; bus.s1_phv_valid = 1'b0; bus.ke_key_valid = 1'b0;
   endtask

   initial begin
      areset           = 1'b1;
      bus.s0_phv_valid = 1'b0;
      bus.s1_phv_valid = 1'b0;
      bus.ke_key_valid = 1'b0;
      bus.s0_phv_data  = '0;
      bus.s1_phv_data  = '0;
      #1;
      reset_dut();
      @(negedge axis_clk);
      chk("reset_parser_valid", bus.ke_parser_valid, 0);
      chk("reset_hdr", bus.ke_pkt_hdr_vec[63:0], 0);
      chk("reset_inflight", bus.inflight, 0);
      chk("reset_done_valid", bus.done_valid, 0);
      chk("reset_done_src", bus.done_src, 0);
      chk("reset_err_orphan", bus.err_orphan, 0);
      next_cyc();
`ifdef KEY_ARB_STRICT_PRIO_EN
      run_strict();
`else
      run_table();
      run_saturated();
`endif
      run_fifo_full();
      run_reset_tags();
      run_random();
      repeat (4) next_cyc();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/key_extract_arb.md
# key_extract_arb

Two-port PHV arbiter and issue sequencer in front of one shared `key_extract` engine per stage. It accepts PHVs from two parser lanes and grants them round-robin. Each accepted PHV goes to the engine as a single-cycle `parser_valid` pulse, spaced by a programmable gap so that no PHV arrives while the engine is still in its key-building state. An in-order tag FIFO records which lane each PHV came from, and every returned key is attributed back to that lane.

## Interface
- `PHV_LEN`, default 1579: PHV width, same as the engine.
- `ISSUE_GAP`, default 2: minimum number of cycles between two issues. Legal range is 2 to 15.
- `TAG_DEPTH`, default 4: number of PHVs allowed in flight. Must be a power of 2, at least 2.
- `axis_clk`, in, 1: the only clock.
- `areset`, in, 1: synchronous, active-high reset.
- `s0_phv_valid`, in, 1: lane-0 PHV present.
- `s0_phv_data`, in, `PHV_LEN`: lane-0 PHV.
- `s0_phv_ready`, out, 1: lane-0 accept. Combinational; a transfer occurs when valid and ready are both high.
- `s1_phv_valid` / `s1_phv_data` / `s1_phv_ready`: lane 1, identical to lane 0.
- `ke_parser_valid`, out, 1: issue pulse to the engine.
- `ke_pkt_hdr_vec`, out, `PHV_LEN`: PHV to the engine. Registered.
- `ke_key_valid`, in, 1: key-done pulse from the engine, one cycle high per key.
- `done_valid`, out, 1: key attributed. Registered pulse.
- `done_src`, out, 1: lane that owns the completed key.
- `inflight`, out, `$clog2(TAG_DEPTH)+1`: current tag FIFO occupancy.
- `err_orphan`, out, 1: pulse when a key returns while no tag is outstanding.

## Operation
- **FSM states:** `IDLE`, `GAP`.
- **Ready rule in `IDLE`:** a lane's ready is high only if that lane is granted and `inflight < TAG_DEPTH`. In `GAP`, both readies are low.
- **Grant, round-robin:**
  - If only one lane is valid, that lane is granted.
  - If both lanes are valid, the lane other than `last_grant` is granted.
  - `last_grant` updates only on an accept. Its reset value is 1, so lane 0 wins the first tie.
- **On accept in `IDLE`:**
  - Register the PHV into `ke_pkt_hdr_vec`.
  - Set `ke_parser_valid` high for exactly the next cycle.
  - Push the source bit into the tag FIFO.
  - Load `gap_cnt` with `ISSUE_GAP-1` and go to `GAP`.
- **`GAP` state:** decrement `gap_cnt` each cycle. When `gap_cnt` is 1 and decrements to 0, go to `IDLE`.
- **`ke_pkt_hdr_vec`** holds its value until the next accept.
- **On `ke_key_valid` with tags outstanding:** pop the tag FIFO head. Next cycle, `done_valid` is 1 and `done_src` is the popped lane.
- **On `ke_key_valid` with the FIFO empty:** no pop. Next cycle, `err_orphan` is 1 and `done_valid` stays 0.
- **Push and pop in the same cycle:**
  - Both happen; `inflight` is unchanged.
  - Ordering is preserved, and the pop returns the older entry.
  - When the FIFO is full, the pop does not make room in that same cycle, because ready was computed from the pre-pop count.
- **Pointer arithmetic:** read/write pointers are `$clog2(TAG_DEPTH)` bits and wrap modulo `TAG_DEPTH`. `inflight` is a separate up/down counter.
- **Data path:** no transformation of the PHV.

## Timing
- **Accept to issue:** 1 cycle. An accept at edge T gives `ke_parser_valid` = 1 during cycle T+1.
- **Issue spacing:** the earliest next accept is T+`ISSUE_GAP`, so issue pulses are at least `ISSUE_GAP` cycles apart.
- **Key to done:** 1 cycle. `ke_key_valid` in cycle K gives `done_valid` in cycle K+1.
- **Throughput:** with `ISSUE_GAP=2`, both lanes saturated, and a prompt engine, one PHV every 2 cycles, alternating lanes.
- **Reset values** (reset sampled high at an edge):
  - `ke_parser_valid` = 0
  - `ke_pkt_hdr_vec` = 0
  - `done_valid` = 0
  - `done_src` = 0
  - `err_orphan` = 0
  - `inflight` = 0
  - FSM = `IDLE`
  - `gap_cnt` = 0
  - `last_grant` = 1
- **Reset mid-operation:** outstanding tags are discarded. Keys returning after reset raise `err_orphan`.
- **Ready during reset:** readies are 0 in every cycle where `areset` is high.

## Configuration
- **`KEY_ARB_STRICT_PRIO_EN` defined:** lane 0 always wins when both lanes are valid. `last_grant` is not used, and lane 1 is granted only when lane 0 is not valid.
- **`KEY_ARB_STRICT_PRIO_EN` undefined:** round-robin as described under Operation.
- **Unaffected by the macro:** all other behaviour and timing.

## Test plan
- **Single issue and completion.** Reset, then drive s0 valid with data `0x…A5` for one accept. Expect:
  - `ke_parser_valid` high for 1 cycle at T+1, with `ke_pkt_hdr_vec` = `0x…A5`.
  - `inflight` = 1.
  - Engine pulses `ke_key_valid` at T+3; expect `done_valid` with `done_src` = 0 at T+4 and `inflight` = 0.
- **Saturated arbitration.** Both lanes valid continuously, `ISSUE_GAP` = 2, engine echoing a key 2 cycles after each issue. Expect:
  - Issue pulses every 2 cycles.
  - Grant order 0,1,0,1,…
  - `done_src` sequence matches the grant order.
  - No `err_orphan`.
- **FIFO full.** Hold `ke_key_valid` at 0 with lane 0 continuously valid. Expect:
  - Exactly 4 accepts, then `s0_phv_ready` stuck at 0 with `inflight` = 4.
  - After one key pulse, `inflight` = 3 and the next accept occurs in the following `IDLE` cycle.
- **Simultaneous push and pop.** Accept in the same cycle as a key pulse with `inflight` = 2. Expect:
  - `inflight` stays 2.
  - The `done_src` of the older entry is reported.
- **Orphan and reset.**
  - Key pulse with an empty FIFO: expect `err_orphan` for 1 cycle and no `done_valid`.
  - Assert `areset` with 3 tags in flight: expect `inflight` = 0; a subsequent key pulse raises `err_orphan`.
- **Strict priority** (compiled with `KEY_ARB_STRICT_PRIO_EN`). Both lanes valid for 6 issues: expect all grants to lane 0, with lane 1 granted only after s0 valid drops.
